motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pwm_driver.sv | 246 ++++++++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - dual H-bridge PWM driver with dead-time reversal and brake
// Optional soft-start ramp compiled in with `define MOTOR_SOFT_START_EN.

module motor_pwm_channel #(
  parameter int DEAD_CYCLES = 50000,
  parameter int RAMP_DIV    = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd_i,
  input  logic [8:0] target_i,
  input  logic [7:0] pwm_cnt_i,
  output logic       in1_o,
  output logic       in2_o,
  output logic       en_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DEAD  = 2'd2,
    BRAKE = 2'd3
  } state_t;

  localparam logic [19:0] DEAD_LOAD = 20'(DEAD_CYCLES - 1);

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [19:0] dead_q, dead_d;
  logic [8:0]  duty_q, duty_d;
  logic        req_rev;
  logic        pwm;

  assign req_rev = (cmd_i == 2'b10);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        case (cmd_i)
          2'b01, 2'b10: begin
            state_d = RUN;
            dir_d   = req_rev;
          end
          2'b11:   state_d = BRAKE;
          default: state_d = IDLE;
        endcase
      end
      RUN: begin
        case (cmd_i)
          2'b00: state_d = IDLE;
          2'b11: state_d = BRAKE;
          default: begin
            if (req_rev != dir_q) begin
              state_d = DEAD;
              dead_d  = DEAD_LOAD;
              dir_d   = req_rev;
            end
          end
        endcase
      end
      DEAD: begin
        case (cmd_i)
          2'b00: state_d = IDLE;
          2'b11: state_d = BRAKE;
          default: begin
            // dir_q holds the pending direction while coasting through dead time
            if (req_rev != dir_q) begin
              dead_d = DEAD_LOAD;
              dir_d  = req_rev;
            end else if (dead_q == 20'd0) begin
              state_d = RUN;
            end else begin
              dead_d = dead_q - 20'd1;
            end
          end
        endcase
      end
      BRAKE: begin
        case (cmd_i)
          2'b00: state_d = IDLE;
          2'b01, 2'b10: begin
            state_d = DEAD;
            dead_d  = DEAD_LOAD;
            dir_d   = req_rev;
          end
          default: state_d = BRAKE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MOTOR_SOFT_START_EN
  localparam logic [15:0] RAMP_MAX = 16'(RAMP_DIV - 1);

  logic [15:0] ramp_q, ramp_d;

  always_comb begin
    duty_d = duty_q;
    ramp_d = ramp_q;
    if (state_d != RUN || state_q != RUN) begin
      duty_d = 9'd0;
      ramp_d = 16'd0;
    end else if (duty_q > target_i) begin
      duty_d = target_i;
      ramp_d = 16'd0;
    end else if (duty_q < target_i) begin
      if (ramp_q == RAMP_MAX) begin
        ramp_d = 16'd0;
        duty_d = duty_q + 9'd1;
      end else begin
        ramp_d = ramp_q + 16'd1;
      end
    end else begin
      ramp_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ramp_q <= 16'd0;
    else     ramp_q <= ramp_d;
  end
`else
  always_comb begin
    duty_d = (state_d == RUN) ? target_i : 9'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      dead_q  <= 20'd0;
      duty_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      duty_q  <= duty_d;
    end
  end

  assign pwm = ({1'b0, pwm_cnt_i} < duty_q);

  always_comb begin
    in1_o = 1'b0;
    in2_o = 1'b0;
    en_o  = 1'b0;
    case (state_q)
      RUN: begin
        in1_o = ~dir_q;
        in2_o = dir_q;
        en_o  = pwm;
      end
      BRAKE: begin
        in1_o = 1'b1;
        in2_o = 1'b1;
        en_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

module motor_pwm_driver #(
  parameter int PWM_DIV     = 4,
  parameter int DEAD_CYCLES = 50000,
  parameter int RAMP_DIV    = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] control_in,
  output logic       l_in1,
  output logic       l_in2,
  output logic       l_en,
  output logic       r_in1,
  output logic       r_in2,
  output logic       r_en,
  output logic [1:0] l_state,
  output logic [1:0] r_state
);

  localparam logic [15:0] PRE_MAX = 16'(PWM_DIV - 1);

  logic [7:0]  cmd_q;
  logic [15:0] pre_q;
  logic [7:0]  pwm_cnt_q;
  logic [8:0]  target;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= 8'd0;
      pre_q     <= 16'd0;
      pwm_cnt_q <= 8'd0;
    end else begin
      cmd_q <= control_in;
      if (pre_q == PRE_MAX) begin
        pre_q     <= 16'd0;
        pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end else begin
        pre_q <= pre_q + 16'd1;
      end
    end
  end

  // speed level n maps to (n+1)*64, so level 3 reaches 256 (always on)
  assign target = {1'b0, cmd_q[3:2], 6'd0} + 9'd64;

  motor_pwm_channel #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_DIV   (RAMP_DIV)
  ) u_left (
    .clk      (clk),
    .rst      (rst),
    .cmd_i    (cmd_q[7:6]),
    .target_i (target),
    .pwm_cnt_i(pwm_cnt_q),
    .in1_o    (l_in1),
    .in2_o    (l_in2),
    .en_o     (l_en),
    .state_o  (l_state)
  );

  motor_pwm_channel #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_DIV   (RAMP_DIV)
  ) u_right (
    .clk      (clk),
    .rst      (rst),
    .cmd_i    (cmd_q[5:4]),
    .target_i (target),
    .pwm_cnt_i(pwm_cnt_q),
    .in1_o    (r_in1),
    .in2_o    (r_in2),
    .en_o     (r_en),
    .state_o  (r_state)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - directed self-checking bench for motor_pwm_driver
module tb_motor_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] control_in;
  logic       l_in1, l_in2, l_en, r_in1, r_in2, r_en;
  logic [1:0] l_state, r_state;

  int checks = 0;
  int fails  = 0;

  motor_pwm_driver #(
    .PWM_DIV    (1),
    .DEAD_CYCLES(8),
    .RAMP_DIV   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .control_in(control_in),
    .l_in1     (l_in1),
    .l_in2     (l_in2),
    .l_en      (l_en),
    .r_in1     (r_in1),
    .r_in2     (r_in2),
    .r_en      (r_en),
    .l_state   (l_state),
    .r_state   (r_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_en(output int l_cnt, output int r_cnt);
    l_cnt = 0;
    r_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (l_en) l_cnt++;
      if (r_en) r_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    control_in = 8'h5C;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state} !== 10'b0) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i,
                 {l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state}, 10'b0);
      end
    end
    control_in = 8'h00;
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_forward_duty();
    int lc, rc;
    control_in = 8'h50;
    tick();
    tick();
    checks++;
    if ({l_state, r_state} !== 4'b0101) begin
      fails++;
      $display("FAIL fwd_state: got %b expected %b", {l_state, r_state}, 4'b0101);
    end
    checks++;
    if ({l_in1, l_in2, r_in1, r_in2} !== 4'b1010) begin
      fails++;
      $display("FAIL fwd_dir: got %b expected %b", {l_in1, l_in2, r_in1, r_in2}, 4'b1010);
    end
`ifndef MOTOR_SOFT_START_EN
    count_en(lc, rc);
    checks++;
    if (lc !== 64 || rc !== 64) begin
      fails++;
      $display("FAIL fwd_duty64: got l=%0d r=%0d expected 64", lc, rc);
    end
`endif
  endtask

`ifndef MOTOR_SOFT_START_EN
  task automatic test_speed_levels();
    int lc, rc;
    control_in = 8'h54;
    tick();
    tick();
    count_en(lc, rc);
    checks++;
    if (lc !== 128 || rc !== 128) begin
      fails++;
      $display("FAIL duty128: got l=%0d r=%0d expected 128", lc, rc);
    end
    control_in = 8'h5C;
    tick();
    tick();
    count_en(lc, rc);
    checks++;
    if (lc !== 256 || rc !== 256) begin
      fails++;
      $display("FAIL duty256: got l=%0d r=%0d expected 256", lc, rc);
    end
    control_in = 8'h50;
    tick();
    tick();
    count_en(lc, rc);
    checks++;
    if (lc !== 64 || rc !== 64) begin
      fails++;
      $display("FAIL duty_back64: got l=%0d r=%0d expected 64", lc, rc);
    end
  endtask
`endif

  task automatic test_reversal();
    int n;
    control_in = 8'h90;
    tick();
    tick();
    n = 0;
    while (l_state == 2'd2 && n < 20) begin
      checks++;
      if ({l_in1, l_in2, l_en} !== 3'b000) begin
        fails++;
        $display("FAIL dead_pins: got %b expected %b", {l_in1, l_in2, l_en}, 3'b000);
      end
      n++;
      tick();
    end
    checks++;
    if (n !== 8) begin
      fails++;
      $display("FAIL dead_len: got %0d expected 8", n);
    end
    checks++;
    if ({l_state, l_in1, l_in2} !== 4'b0101) begin
      fails++;
      $display("FAIL rev_run: got %b expected %b", {l_state, l_in1, l_in2}, 4'b0101);
    end
    checks++;
    if ({r_state, r_in1, r_in2} !== 4'b0110) begin
      fails++;
      $display("FAIL right_indep: got %b expected %b", {r_state, r_in1, r_in2}, 4'b0110);
    end
  endtask

  task automatic test_brake_in_dead();
    int n;
    control_in = 8'h50;
    tick();
    tick();
    checks++;
    if (l_state !== 2'd2) begin
      fails++;
      $display("FAIL bd_enter_dead: got %0d expected 2", l_state);
    end
    tick();
    tick();
    control_in = 8'hD0;
    n = 0;
    while (l_state == 2'd2 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 2) begin
      fails++;
      $display("FAIL bd_latency: got %0d expected 2", n);
    end
    checks++;
    if ({l_state, l_in1, l_in2, l_en} !== 5'b11111) begin
      fails++;
      $display("FAIL bd_brake: got %b expected %b", {l_state, l_in1, l_in2, l_en}, 5'b11111);
    end
  endtask

  task automatic test_coast();
    control_in = 8'h00;
    tick();
    tick();
    checks++;
    if ({l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state} !== 10'b0) begin
      fails++;
      $display("FAIL coast_idle: got %b expected %b",
               {l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state}, 10'b0);
    end
  endtask

  task automatic test_reset_mid_dead();
    logic seen_dead;
    control_in = 8'hF0;
    tick();
    tick();
    checks++;
    if ({l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state} !== 10'b1111111111) begin
      fails++;
      $display("FAIL both_brake: got %b expected %b",
               {l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state}, 10'b1111111111);
    end
    control_in = 8'h40;
    tick();
    tick();
    checks++;
    if ({l_state, r_state} !== 4'b1000) begin
      fails++;
      $display("FAIL brake_to_dead: got %b expected %b", {l_state, r_state}, 4'b1000);
    end
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state} !== 10'b0) begin
      fails++;
      $display("FAIL mid_dead_reset: got %b expected %b",
               {l_in1, l_in2, l_en, r_in1, r_in2, r_en, l_state, r_state}, 10'b0);
    end
    rst = 1'b0;
    seen_dead = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (l_state == 2'd2) seen_dead = 1'b1;
    end
    checks++;
    if (seen_dead !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_dead: got %b expected 0", seen_dead);
    end
    checks++;
    if ({l_state, l_in1, l_in2, r_state} !== 6'b011000) begin
      fails++;
      $display("FAIL post_reset_run: got %b expected %b", {l_state, l_in1, l_in2, r_state}, 6'b011000);
    end
  endtask

`ifdef MOTOR_SOFT_START_EN
  task automatic test_soft_start();
    control_in = 8'h00;
    tick();
    tick();
    control_in = 8'h5C;
    tick();
    tick();
    checks++;
    if (l_state !== 2'd1 || dut.u_left.duty_q !== 9'd0) begin
      fails++;
      $display("FAIL ss_start: got state=%0d duty=%0d expected 1/0", l_state, dut.u_left.duty_q);
    end
    for (int i = 0; i < 510; i++) tick();
    checks++;
    if (dut.u_left.duty_q !== 9'd255) begin
      fails++;
      $display("FAIL ss_510: got %0d expected 255", dut.u_left.duty_q);
    end
    tick();
    tick();
    checks++;
    if (dut.u_left.duty_q !== 9'd256) begin
      fails++;
      $display("FAIL ss_512: got %0d expected 256", dut.u_left.duty_q);
    end
    control_in = 8'h50;
    tick();
    tick();
    checks++;
    if (dut.u_left.duty_q !== 9'd64) begin
      fails++;
      $display("FAIL ss_drop: got %0d expected 64", dut.u_left.duty_q);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    control_in = 8'h00;
    test_reset();
    test_forward_duty();
`ifndef MOTOR_SOFT_START_EN
    test_speed_levels();
`endif
    test_reversal();
    test_brake_in_dead();
    test_coast();
    test_reset_mid_dead();
`ifdef MOTOR_SOFT_START_EN
    test_soft_start();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
